// File: rtl/CONFIG.sv
// Shared synthesis configuration: voice count and per-voice state record.
package CONFIG;

    localparam int unsigned NUM_VOICES = 8;
    localparam int unsigned NOTE_W     = 7;
    localparam int unsigned VEL_W      = 7;
    // Rank field wide enough for the largest supported voice count (16).
    localparam int unsigned RANK_W     = 4;

    typedef struct packed {
        logic              active;
        logic              sustained;
        logic [NOTE_W-1:0] note;
        logic [VEL_W-1:0]  velocity;
        logic [RANK_W-1:0] rank;
    } voice_state_t;

endpackage

// File: rtl/MIDI.sv
// Shared MIDI message definitions used by the synthesis front end.
package MIDI;

    localparam int unsigned DATA_W = 7;

    typedef enum logic [3:0] {
        NOTE_OFF         = 4'h8,
        NOTE_ON          = 4'h9,
        POLY_PRESSURE    = 4'hA,
        CONTROL_CHANGE   = 4'hB,
        PROGRAM_CHANGE   = 4'hC,
        CHANNEL_PRESSURE = 4'hD,
        PITCH_BEND       = 4'hE,
        SYSTEM           = 4'hF
    } message_type_t;

    typedef struct packed {
        message_type_t     message_type;
        logic [DATA_W-1:0] data_byte1;
        logic [DATA_W-1:0] data_byte2;
    } message_t;

    localparam logic [DATA_W-1:0] SUSTAIN_CC       = 7'd64;
    localparam logic [DATA_W-1:0] ALL_NOTES_OFF_CC = 7'd123;

endpackage

// File: rtl/voice_select.sv
// Combinational voice search: note match, first free voice and oldest voice.
module voice_select #(
    parameter  int unsigned NUM_VOICES = CONFIG::NUM_VOICES,
    localparam int unsigned IDX_W      = $clog2(NUM_VOICES)
) (
    input  CONFIG::voice_state_t [NUM_VOICES-1:0] voices,
    input  logic [CONFIG::NOTE_W-1:0]              note,
    output logic [IDX_W-1:0]                       match_index,
    output logic                                   match_valid,
    output logic [IDX_W-1:0]                       free_index,
    output logic                                   free_valid,
    output logic [IDX_W-1:0]                       oldest_index
);

    localparam int unsigned RANK_W = CONFIG::RANK_W;

    // Scan high to low so the lowest matching index wins each search.
    always_comb begin
        match_index  = '0;
        match_valid  = 1'b0;
        free_index   = '0;
        free_valid   = 1'b0;
        oldest_index = '0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            // Sustained voices are always active, so active covers both.
            if (voices[i].active && (voices[i].note == note)) begin
                match_index = IDX_W'(i);
                match_valid = 1'b1;
            end
            if (!voices[i].active) begin
                free_index = IDX_W'(i);
                free_valid = 1'b1;
            end
            if (voices[i].rank == RANK_W'(NUM_VOICES - 1)) begin
                oldest_index = IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: maps MIDI note/sustain messages onto voices.
module voice_allocator
    import MIDI::*;
#(
    parameter int unsigned NUM_VOICES = CONFIG::NUM_VOICES
) (
    input  logic                                           clock_50_000_000,
    input  logic                                           reset_l,
    input  message_t                                       message,
    input  logic                                           message_ready,
    output logic [NUM_VOICES-1:0]                          voice_active,
    output logic [NUM_VOICES-1:0][CONFIG::NOTE_W-1:0]      voice_note,
    output logic [NUM_VOICES-1:0][CONFIG::VEL_W-1:0]       voice_velocity,
    output logic [NUM_VOICES-1:0]                          voice_trigger,
    output logic                                           message_dropped
);

    localparam int unsigned IDX_W  = $clog2(NUM_VOICES);
    localparam int unsigned RANK_W = CONFIG::RANK_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        COMMIT = 2'd2
    } state_t;

    state_t state;
    state_t next_state;

    logic latch_c;
    logic capture_c;
    logic commit_c;
    logic drop_c;

    message_t msg_q;

    CONFIG::voice_state_t [NUM_VOICES-1:0] voices;
    CONFIG::voice_state_t [NUM_VOICES-1:0] voices_next;
    logic                                  sustain;
    logic                                  sustain_next;
    logic [NUM_VOICES-1:0]                 trigger_next;

    logic [IDX_W-1:0] sel_match_index;
    logic             sel_match_valid;
    logic [IDX_W-1:0] sel_free_index;
    logic             sel_free_valid;
    logic [IDX_W-1:0] sel_oldest_index;

    logic [IDX_W-1:0] match_index_q;
    logic             match_valid_q;
    logic [IDX_W-1:0] free_index_q;
    logic             free_valid_q;
    logic [IDX_W-1:0] oldest_index_q;

    logic              alloc;
    logic [IDX_W-1:0]  alloc_index;
    logic [RANK_W-1:0] old_rank;

    // State register.
    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: one search cycle and one commit cycle per message.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (message_ready) next_state = SEARCH;
            SEARCH:  next_state = COMMIT;
            COMMIT:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM control decode; strobes arriving while busy are dropped.
    always_comb begin
        latch_c   = 1'b0;
        capture_c = 1'b0;
        commit_c  = 1'b0;
        drop_c    = 1'b0;
        case (state)
            IDLE:    latch_c = message_ready;
            SEARCH: begin
                capture_c = 1'b1;
                drop_c    = message_ready;
            end
            COMMIT: begin
                commit_c  = 1'b1;
                drop_c    = message_ready;
            end
            default: ;
        endcase
    end

    // Message latch, loaded only when the block accepts a strobe.
    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            msg_q <= '{message_type: NOTE_OFF, data_byte1: '0, data_byte2: '0};
        end else if (latch_c) begin
            msg_q <= message;
        end
    end

    voice_select #(
        .NUM_VOICES (NUM_VOICES)
    ) u_select (
        .voices       (voices),
        .note         (msg_q.data_byte1),
        .match_index  (sel_match_index),
        .match_valid  (sel_match_valid),
        .free_index   (sel_free_index),
        .free_valid   (sel_free_valid),
        .oldest_index (sel_oldest_index)
    );

    // Capture search results so the commit cycle works from registers.
    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            match_index_q  <= '0;
            match_valid_q  <= 1'b0;
            free_index_q   <= '0;
            free_valid_q   <= 1'b0;
            oldest_index_q <= '0;
        end else if (capture_c) begin
            match_index_q  <= sel_match_index;
            match_valid_q  <= sel_match_valid;
            free_index_q   <= sel_free_index;
            free_valid_q   <= sel_free_valid;
            oldest_index_q <= sel_oldest_index;
        end
    end

    // Voice update for the latched message; a retriggered note also becomes newest.
    always_comb begin
        voices_next  = voices;
        sustain_next = sustain;
        trigger_next = '0;
        alloc        = 1'b0;
        alloc_index  = '0;
        old_rank     = '0;
        case (msg_q.message_type)
            NOTE_ON: begin
                alloc = 1'b1;
                if (match_valid_q) begin
                    alloc_index = match_index_q;
                end else if (free_valid_q) begin
                    alloc_index = free_index_q;
                end else begin
                    alloc_index = oldest_index_q;
                end
            end
            NOTE_OFF: begin
                if (match_valid_q) begin
                    if (sustain) begin
                        voices_next[match_index_q].sustained = 1'b1;
                    end else begin
                        voices_next[match_index_q].active = 1'b0;
                    end
                end
            end
            CONTROL_CHANGE: begin
                if (msg_q.data_byte1 == SUSTAIN_CC) begin
                    if (msg_q.data_byte2[6]) begin
                        sustain_next = 1'b1;
                    end else begin
                        sustain_next = 1'b0;
                        for (int i = 0; i < NUM_VOICES; i++) begin
                            if (voices[i].sustained) begin
                                voices_next[i].active    = 1'b0;
                                voices_next[i].sustained = 1'b0;
                            end
                        end
                    end
                end else if (msg_q.data_byte1 == ALL_NOTES_OFF_CC) begin
                    for (int i = 0; i < NUM_VOICES; i++) begin
                        voices_next[i].active    = 1'b0;
                        voices_next[i].sustained = 1'b0;
                    end
                end
            end
            default: ;
        endcase
        if (alloc) begin
            old_rank = voices[alloc_index].rank;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (IDX_W'(i) == alloc_index) begin
                    voices_next[i].rank = '0;
                end else if (voices[i].rank < old_rank) begin
                    voices_next[i].rank = voices[i].rank + RANK_W'(1);
                end
            end
            voices_next[alloc_index].active    = 1'b1;
            voices_next[alloc_index].sustained = 1'b0;
            voices_next[alloc_index].note      = msg_q.data_byte1;
            voices_next[alloc_index].velocity  = msg_q.data_byte2;
            trigger_next[alloc_index]          = 1'b1;
        end
    end

    // Voice state and sustain pedal; reset gives voice i rank i.
    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
                voices[i] <= '{active: 1'b0, sustained: 1'b0, note: '0,
                               velocity: '0, rank: RANK_W'(i)};
            end
            sustain <= 1'b0;
        end else if (commit_c) begin
            voices  <= voices_next;
            sustain <= sustain_next;
        end
    end

    // Registered pulses: trigger after commit, dropped after a busy strobe.
    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            voice_trigger   <= '0;
            message_dropped <= 1'b0;
        end else begin
            voice_trigger   <= commit_c ? trigger_next : '0;
            message_dropped <= drop_c;
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_out
        assign voice_active[g]   = voices[g].active;
        assign voice_note[g]     = voices[g].note;
        assign voice_velocity[g] = voices[g].velocity;
    end

endmodule

// File: tb/tb_voice_allocator.sv
// Randomized self-checking bench for voice_allocator against an LRU-list model.
module tb_voice_allocator;
    import MIDI::*;

    localparam int N = 8;

    logic                clock_50_000_000 = 1'b0;
    logic                reset_l;
    message_t            message;
    logic                message_ready;
    logic [N-1:0]        voice_active;
    logic [N-1:0][6:0]   voice_note;
    logic [N-1:0][6:0]   voice_velocity;
    logic [N-1:0]        voice_trigger;
    logic                message_dropped;

    int checks = 0;
    int errors = 0;

    // Reference model: flags per voice plus an age list (front = newest).
    bit m_act[N];
    bit m_sus[N];
    int m_note[N];
    int m_vel[N];
    int age_q[$];
    bit m_sustain;

    voice_allocator #(.NUM_VOICES(N)) dut (
        .clock_50_000_000 (clock_50_000_000),
        .reset_l          (reset_l),
        .message          (message),
        .message_ready    (message_ready),
        .voice_active     (voice_active),
        .voice_note       (voice_note),
        .voice_velocity   (voice_velocity),
        .voice_trigger    (voice_trigger),
        .message_dropped  (message_dropped)
    );

    always #10 clock_50_000_000 = ~clock_50_000_000;

    initial begin
        #2000000;
        $display("FAIL watchdog expired got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic message_t mk(input message_type_t t, input int b1, input int b2);
        message_t m;
        m.message_type = t;
        m.data_byte1   = 7'(b1);
        m.data_byte2   = 7'(b2);
        return m;
    endfunction

    function automatic void model_reset();
        age_q.delete();
        for (int i = 0; i < N; i++) begin
            m_act[i]  = 1'b0;
            m_sus[i]  = 1'b0;
            m_note[i] = 0;
            m_vel[i]  = 0;
            age_q.push_back(i);
        end
        m_sustain = 1'b0;
    endfunction

    function automatic void make_newest(input int k);
        int pos = -1;
        for (int j = 0; j < age_q.size(); j++) if (age_q[j] == k) pos = j;
        if (pos >= 0) age_q.delete(pos);
        age_q.push_front(k);
    endfunction

    // Applies one message to the model; returns the triggered voice or -1.
    function automatic int model_apply(input message_t m);
        int k = -1;
        int n = int'(m.data_byte1);
        int v = int'(m.data_byte2);
        case (m.message_type)
            NOTE_ON: begin
                for (int i = 0; i < N; i++) if (m_act[i] && m_note[i] == n) k = i;
                if (k < 0) begin
                    for (int i = N - 1; i >= 0; i--) if (!m_act[i]) k = i;
                end
                if (k < 0) k = age_q[age_q.size() - 1];
                m_act[k]  = 1'b1;
                m_sus[k]  = 1'b0;
                m_note[k] = n;
                m_vel[k]  = v;
                make_newest(k);
            end
            NOTE_OFF: begin
                for (int i = 0; i < N; i++) begin
                    if (m_act[i] && m_note[i] == n) begin
                        if (m_sustain) m_sus[i] = 1'b1;
                        else m_act[i] = 1'b0;
                    end
                end
            end
            CONTROL_CHANGE: begin
                if (n == 64) begin
                    if (v >= 64) begin
                        m_sustain = 1'b1;
                    end else begin
                        m_sustain = 1'b0;
                        for (int i = 0; i < N; i++) begin
                            if (m_sus[i]) begin
                                m_act[i] = 1'b0;
                                m_sus[i] = 1'b0;
                            end
                        end
                    end
                end else if (n == 123) begin
                    for (int i = 0; i < N; i++) begin
                        m_act[i] = 1'b0;
                        m_sus[i] = 1'b0;
                    end
                end
            end
            default: ;
        endcase
        return k;
    endfunction

    task automatic check_state(input string ctx, input int exp_trig);
        logic [N-1:0] ea;
        logic [N-1:0] et;
        ea = '0;
        et = '0;
        for (int i = 0; i < N; i++) ea[i] = m_act[i];
        if (exp_trig >= 0) et[exp_trig] = 1'b1;
        check_eq({ctx, ".trigger"}, 64'(voice_trigger), 64'(et));
        check_eq({ctx, ".active"}, 64'(voice_active), 64'(ea));
        for (int i = 0; i < N; i++) begin
            check_eq($sformatf("%s.note%0d", ctx, i), 64'(voice_note[i]), 64'(m_note[i]));
            check_eq($sformatf("%s.vel%0d", ctx, i), 64'(voice_velocity[i]), 64'(m_vel[i]));
        end
    endtask

    // One accepted message; outputs are checked three cycles after the strobe.
    task automatic send(input message_t m, input string ctx);
        int et;
        @(negedge clock_50_000_000);
        check_eq({ctx, ".trig_idle"}, 64'(voice_trigger), 64'(0));
        message       = m;
        message_ready = 1'b1;
        @(negedge clock_50_000_000);
        message_ready = 1'b0;
        @(negedge clock_50_000_000);
        check_eq({ctx, ".no_drop"}, 64'(message_dropped), 64'(0));
        @(negedge clock_50_000_000);
        et = model_apply(m);
        check_state(ctx, et);
    endtask

    // Second strobe lands in SEARCH and must be dropped.
    task automatic send_pair(input message_t m1, input message_t m2, input string ctx);
        int et;
        @(negedge clock_50_000_000);
        check_eq({ctx, ".trig_idle"}, 64'(voice_trigger), 64'(0));
        message       = m1;
        message_ready = 1'b1;
        @(negedge clock_50_000_000);
        message       = m2;
        message_ready = 1'b1;
        @(negedge clock_50_000_000);
        message_ready = 1'b0;
        check_eq({ctx, ".dropped"}, 64'(message_dropped), 64'(1));
        @(negedge clock_50_000_000);
        check_eq({ctx, ".drop_end"}, 64'(message_dropped), 64'(0));
        et = model_apply(m1);
        check_state(ctx, et);
    endtask

    task automatic do_reset(input string ctx);
        @(negedge clock_50_000_000);
        reset_l       = 1'b0;
        message_ready = 1'b0;
        @(negedge clock_50_000_000);
        @(negedge clock_50_000_000);
        reset_l = 1'b1;
        model_reset();
        check_state(ctx, -1);
        check_eq({ctx, ".dropped"}, 64'(message_dropped), 64'(0));
    endtask

    function automatic message_t random_message();
        int r = $urandom_range(0, 99);
        if (r < 40) return mk(NOTE_ON, 60 + $urandom_range(0, 11), $urandom_range(1, 127));
        if (r < 68) return mk(NOTE_OFF, 60 + $urandom_range(0, 11), $urandom_range(0, 127));
        if (r < 80) return mk(CONTROL_CHANGE, 64, $urandom_range(0, 127));
        if (r < 83) return mk(CONTROL_CHANGE, 123, $urandom_range(0, 127));
        if (r < 90) return mk(CONTROL_CHANGE, $urandom_range(0, 63), $urandom_range(0, 127));
        case ($urandom_range(0, 2))
            0:       return mk(PROGRAM_CHANGE, $urandom_range(0, 127), $urandom_range(0, 127));
            1:       return mk(PITCH_BEND, $urandom_range(0, 127), $urandom_range(0, 127));
            default: return mk(POLY_PRESSURE, 60 + $urandom_range(0, 11), $urandom_range(0, 127));
        endcase
    endfunction

    initial begin
        reset_l       = 1'b0;
        message_ready = 1'b0;
        message       = mk(NOTE_OFF, 0, 0);
        model_reset();

        do_reset("reset");

        // First note lands on voice 0.
        send(mk(NOTE_ON, 60, 100), "first_on");
        check_eq("first_on.note0_const", 64'(voice_note[0]), 64'(60));
        check_eq("first_on.vel0_const", 64'(voice_velocity[0]), 64'(100));

        // Fill every voice, then one more note steals the oldest (voice 0).
        do_reset("reset_fill");
        for (int i = 0; i <= N; i++) send(mk(NOTE_ON, 60 + i, 90), $sformatf("fill%0d", i));
        check_eq("steal.note0_const", 64'(voice_note[0]), 64'(60 + N));
        check_eq("steal.note1_const", 64'(voice_note[1]), 64'(61));

        // Sustain holds a released note until the pedal lifts.
        do_reset("reset_sus");
        send(mk(CONTROL_CHANGE, 64, 127), "sus_on");
        send(mk(NOTE_ON, 60, 100), "sus_note");
        send(mk(NOTE_OFF, 60, 0), "sus_off_note");
        check_eq("sus.held_const", 64'(voice_active[0]), 64'(1));
        send(mk(CONTROL_CHANGE, 64, 0), "sus_release");
        check_eq("sus.released_const", 64'(voice_active[0]), 64'(0));

        // Retriggering a held note reuses its voice.
        do_reset("reset_retrig");
        send(mk(NOTE_ON, 60, 100), "retrig_a");
        send(mk(NOTE_ON, 60, 50), "retrig_b");
        check_eq("retrig.one_voice_const", 64'(voice_active), 64'(1));
        check_eq("retrig.vel_const", 64'(voice_velocity[0]), 64'(50));

        // Busy strobe dropped; all-notes-off clears every voice.
        do_reset("reset_drop");
        send_pair(mk(NOTE_ON, 60, 100), mk(NOTE_ON, 62, 90), "drop");
        check_eq("drop.first_only_const", 64'(voice_active), 64'(1));
        send(mk(NOTE_ON, 65, 70), "pre_cc123");
        send(mk(CONTROL_CHANGE, 123, 0), "cc123");
        check_eq("cc123.all_off_const", 64'(voice_active), 64'(0));

        // Reset asserted while the block is searching.
        send(mk(NOTE_ON, 70, 70), "pre_midreset");
        @(negedge clock_50_000_000);
        message       = mk(NOTE_ON, 71, 71);
        message_ready = 1'b1;
        @(negedge clock_50_000_000);
        message_ready = 1'b0;
        reset_l       = 1'b0;
        #1;
        model_reset();
        check_state("midreset", -1);
        check_eq("midreset.dropped", 64'(message_dropped), 64'(0));
        @(negedge clock_50_000_000);
        reset_l = 1'b1;
        send(mk(NOTE_ON, 64, 77), "after_midreset");
        check_eq("after_midreset.voice0_const", 64'(voice_active), 64'(1));

        // Randomized traffic, with occasional back-to-back strobes.
        do_reset("reset_rand");
        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 19) == 0) begin
                send_pair(random_message(), random_message(), $sformatf("rand_pair%0d", t));
            end else begin
                send(random_message(), $sformatf("rand%0d", t));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
